// File: rtl/constants_pkg.sv
// Shared memory-system widths used by the processor datapath and its I/O blocks.
package constants_pkg;
    localparam int MEMORY_DATA_BITS    = 16;
    localparam int MEMORY_ADDRESS_BITS = 16;
endpackage

// File: rtl/memory_input_ports_if.sv
// Bundle of the processor read bus plus the four external input-port handshakes.
interface memory_input_ports_if;
    import constants_pkg::*;

    logic                           rd_mem_en;
    logic [MEMORY_ADDRESS_BITS-1:0] rd_mem_addr;
    logic [MEMORY_DATA_BITS-1:0]    rd_io_data;
    logic                           rd_io_hit;
    logic                           rd_io_valid;

    logic [MEMORY_DATA_BITS-1:0]    in_port0;
    logic [MEMORY_DATA_BITS-1:0]    in_port1;
    logic [MEMORY_DATA_BITS-1:0]    in_port2;
    logic [MEMORY_DATA_BITS-1:0]    in_port3;
    logic                           in_port0_valid;
    logic                           in_port1_valid;
    logic                           in_port2_valid;
    logic                           in_port3_valid;
    logic                           in_port0_ready;
    logic                           in_port1_ready;
    logic                           in_port2_ready;
    logic                           in_port3_ready;

    modport master (
        output rd_mem_en, rd_mem_addr,
        input  rd_io_data, rd_io_hit, rd_io_valid,
        output in_port0, in_port1, in_port2, in_port3,
        output in_port0_valid, in_port1_valid, in_port2_valid, in_port3_valid,
        input  in_port0_ready, in_port1_ready, in_port2_ready, in_port3_ready
    );

    modport slave (
        input  rd_mem_en, rd_mem_addr,
        output rd_io_data, rd_io_hit, rd_io_valid,
        input  in_port0, in_port1, in_port2, in_port3,
        input  in_port0_valid, in_port1_valid, in_port2_valid, in_port3_valid,
        output in_port0_ready, in_port1_ready, in_port2_ready, in_port3_ready
    );
endinterface

// File: rtl/memory_input_ports.sv
// Four memory-mapped one-entry input buffers plus a status register, read by the
// processor with one cycle of latency.
module memory_input_ports
    import constants_pkg::*;
#(
    parameter logic [MEMORY_ADDRESS_BITS-1:0] PORT_BASE_ADDR = 'hfffc,
    parameter logic [MEMORY_ADDRESS_BITS-1:0] STATUS_ADDR    = 'hfffb
) (
    input  logic                 clk,
    input  logic                 reset_n,
    memory_input_ports_if.slave  bus
);
    localparam int DW = MEMORY_DATA_BITS;

    logic [DW-1:0] w_inData [4];
    logic [3:0]    w_inValid;
    logic [3:0]    w_portSel;
    logic [3:0]    w_capture;
    logic [3:0]    w_overrunEvent;
    logic          w_statusSel;
    logic          w_hit;
    logic [DW-1:0] w_status;
    logic [DW-1:0] w_rdNext;

    logic [DW-1:0] r_hold [4];
    logic [3:0]    r_full;
    logic [3:0]    r_overrun;
    logic [DW-1:0] r_rdData;
    logic          r_rdValid;

    assign w_inData[0] = bus.in_port0;
    assign w_inData[1] = bus.in_port1;
    assign w_inData[2] = bus.in_port2;
    assign w_inData[3] = bus.in_port3;
    assign w_inValid   = {bus.in_port3_valid, bus.in_port2_valid,
                          bus.in_port1_valid, bus.in_port0_valid};

    assign bus.in_port0_ready = ~r_full[0];
    assign bus.in_port1_ready = ~r_full[1];
    assign bus.in_port2_ready = ~r_full[2];
    assign bus.in_port3_ready = ~r_full[3];

    // Offers against a full buffer are dropped and flagged instead of captured.
    for (genvar n = 0; n < 4; n++) begin : g_port
        assign w_portSel[n]      = bus.rd_mem_en &&
                                   (bus.rd_mem_addr == PORT_BASE_ADDR + MEMORY_ADDRESS_BITS'(n));
        assign w_capture[n]      = w_inValid[n] & ~r_full[n];
        assign w_overrunEvent[n] = w_inValid[n] &  r_full[n];
    end

    assign w_statusSel = bus.rd_mem_en && (bus.rd_mem_addr == STATUS_ADDR);
    assign w_hit       = (|w_portSel) | w_statusSel;

    always_comb begin
        w_status      = '0;
        w_status[7:0] = {r_overrun, r_full};
        w_rdNext      = r_rdData;
        if (w_statusSel) w_rdNext = w_status;
        for (int n = 0; n < 4; n++) begin
            if (w_portSel[n]) w_rdNext = r_hold[n];
        end
    end

    // A port read always returns the pre-edge hold value, even when a capture lands at the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 4; n++) r_hold[n] <= '0;
            r_full    <= '0;
            r_overrun <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_capture[n]) r_hold[n] <= w_inData[n];
            end
            r_full    <= w_capture | (r_full & ~w_portSel);
            r_overrun <= w_overrunEvent | (r_overrun & ~{4{w_statusSel}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdData  <= w_rdNext;
            r_rdValid <= w_hit;
        end
    end

    assign bus.rd_io_hit   = w_hit;
    assign bus.rd_io_data  = r_rdData;
    assign bus.rd_io_valid = r_rdValid;
endmodule

// File: tb/tb_memory_input_ports.sv
// Directed plus randomized bench for memory_input_ports against a per-port buffer model.
module tb_memory_input_ports;
    import constants_pkg::*;

    localparam int DW = MEMORY_DATA_BITS;
    localparam int AW = MEMORY_ADDRESS_BITS;
    localparam logic [AW-1:0] BASE = 'hfffc;
    localparam logic [AW-1:0] STAT = 'hfffb;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   nChecks = 0;
    int   nFail   = 0;

    memory_input_ports_if bus();

    memory_input_ports #(.PORT_BASE_ADDR(BASE), .STATUS_ADDR(STAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mHold [4];
    bit            mFull [4];
    bit            mOver [4];
    logic [DW-1:0] mData;
    bit            mValid;

    logic          curEn;
    logic [AW-1:0] curAddr;
    logic [3:0]    curVld;
    logic [DW-1:0] curD [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dutReady();
        return {bus.in_port3_ready, bus.in_port2_ready, bus.in_port1_ready, bus.in_port0_ready};
    endfunction

    function automatic logic [3:0] modelReady();
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = !mFull[n];
        return r;
    endfunction

    function automatic logic [DW-1:0] modelStatus();
        int s;
        s = 0;
        for (int n = 0; n < 4; n++) begin
            if (mFull[n]) s += (1 << n);
            if (mOver[n]) s += (16 << n);
        end
        return DW'(s);
    endfunction

    task automatic modelReset();
        for (int n = 0; n < 4; n++) begin
            mHold[n] = '0;
            mFull[n] = 0;
            mOver[n] = 0;
        end
        mData  = '0;
        mValid = 0;
    endtask

    // Called just after a falling edge; leaves inputs settled for the combinational checks.
    task automatic applyStimulus(input logic en, input logic [AW-1:0] addr, input logic [3:0] vld,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        curEn = en; curAddr = addr; curVld = vld;
        curD[0] = d0; curD[1] = d1; curD[2] = d2; curD[3] = d3;
        bus.rd_mem_en      = en;
        bus.rd_mem_addr    = addr;
        bus.in_port0       = d0;
        bus.in_port1       = d1;
        bus.in_port2       = d2;
        bus.in_port3       = d3;
        bus.in_port0_valid = vld[0];
        bus.in_port1_valid = vld[1];
        bus.in_port2_valid = vld[2];
        bus.in_port3_valid = vld[3];
        #1;
    endtask

    // Compare against the model, advance it by one clock, then check the registered outputs.
    task automatic runCycle();
        int  sel;
        bit  expHit;
        bit  wasFull [4];
        sel = -1;
        for (int n = 0; n < 4; n++)
            if (curAddr == BASE + AW'(n)) sel = n;
        if (curAddr == STAT) sel = 4;
        expHit = curEn && (sel >= 0);
        checkOutput("rd_io_hit", bus.rd_io_hit, expHit);
        checkOutput("in_ready", dutReady(), modelReady());

        if (expHit) mData = (sel == 4) ? modelStatus() : mHold[sel];
        mValid = expHit;
        for (int n = 0; n < 4; n++) wasFull[n] = mFull[n];
        if (expHit && sel < 4) mFull[sel] = 0;
        if (expHit && sel == 4)
            for (int n = 0; n < 4; n++) mOver[n] = 0;
        for (int n = 0; n < 4; n++) begin
            if (curVld[n]) begin
                if (wasFull[n]) mOver[n] = 1;
                else begin
                    mHold[n] = curD[n];
                    mFull[n] = 1;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        checkOutput("rd_io_valid", bus.rd_io_valid, mValid);
        checkOutput("rd_io_data", bus.rd_io_data, mData);
    endtask

    task automatic doRead(input logic [AW-1:0] addr);
        applyStimulus(1'b1, addr, 4'b0000, '0, '0, '0, '0);
        runCycle();
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, '0, 4'b0000, '0, '0, '0, '0);
        runCycle();
    endtask

    initial begin
        logic [3:0]    rv;
        logic [AW-1:0] ra;
        int            pick;

        modelReset();
        applyStimulus(1'b0, '0, 4'b0000, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("reset_data", bus.rd_io_data, 0);
        checkOutput("reset_valid", bus.rd_io_valid, 0);
        checkOutput("reset_ready", dutReady(), 4'hf);
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, 4'b0000, '0, '0, '0, '0);
        runCycle();

        // Fresh after reset: port 0 and status both read back zero.
        doRead('hfffc);
        checkOutput("post_reset_valid", bus.rd_io_valid, 1);
        checkOutput("post_reset_port0", bus.rd_io_data, 0);
        doRead('hfffb);
        checkOutput("post_reset_status", bus.rd_io_data, 0);

        // Single capture on port 2.
        applyStimulus(1'b0, '0, 4'b0100, '0, '0, 'h5a, '0);
        runCycle();
        checkOutput("port2_ready_low", bus.in_port2_ready, 0);
        doRead('hfffb);
        checkOutput("status_full2", bus.rd_io_data, 'h04);
        doRead('hfffe);
        checkOutput("port2_data", bus.rd_io_data, 'h5a);
        checkOutput("port2_ready_back", bus.in_port2_ready, 1);

        // Overrun on port 1.
        applyStimulus(1'b0, '0, 4'b0010, '0, 'h11, '0, '0);
        runCycle();
        applyStimulus(1'b0, '0, 4'b0010, '0, 'h22, '0, '0);
        runCycle();
        doRead('hfffb);
        checkOutput("status_overrun1", bus.rd_io_data, 'h22);
        doRead('hfffd);
        checkOutput("port1_kept_first", bus.rd_io_data, 'h11);
        doRead('hfffb);
        checkOutput("status_cleared", bus.rd_io_data, 'h00);

        // An overrun in the same cycle as a status read survives the clear.
        applyStimulus(1'b0, '0, 4'b0010, '0, 'h33, '0, '0);
        runCycle();
        applyStimulus(1'b1, STAT, 4'b0010, '0, 'h44, '0, '0);
        runCycle();
        checkOutput("status_before_race", bus.rd_io_data, 'h02);
        doRead('hfffb);
        checkOutput("status_overrun_wins", bus.rd_io_data, 'h22);
        doRead('hfffd);
        checkOutput("port1_race_data", bus.rd_io_data, 'h33);
        doRead('hfffb);

        // All four capture while port 0 (empty) is read.
        applyStimulus(1'b0, '0, 4'b0001, 'h77, '0, '0, '0);
        runCycle();
        doRead('hfffc);
        applyStimulus(1'b1, 'hfffc, 4'b1111, 'hb0, 'hb1, 'hb2, 'hb3);
        runCycle();
        checkOutput("empty_read_old_hold", bus.rd_io_data, 'h77);
        doRead('hfffb);
        checkOutput("status_all_full", bus.rd_io_data, 'h0f);
        for (int n = 0; n < 4; n++) doRead(BASE + AW'(n));

        // Back-to-back port reads.
        applyStimulus(1'b0, '0, 4'b1111, 'ha0, 'ha1, 'ha2, 'ha3);
        runCycle();
        for (int n = 0; n < 4; n++) begin
            doRead(BASE + AW'(n));
            checkOutput("b2b_valid", bus.rd_io_valid, 1);
            checkOutput("b2b_data", bus.rd_io_data, 'ha0 + n);
        end
        applyStimulus(1'b1, 'h1234, 4'b0000, '0, '0, '0, '0);
        checkOutput("unmapped_hit", bus.rd_io_hit, 0);
        runCycle();

        // Asynchronous reset between edges with every port full.
        applyStimulus(1'b0, '0, 4'b1111, 'hc0, 'hc1, 'hc2, 'hc3);
        runCycle();
        doRead('hfffd);
        applyStimulus(1'b0, '0, 4'b0000, '0, '0, '0, '0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_data", bus.rd_io_data, 0);
        checkOutput("async_reset_valid", bus.rd_io_valid, 0);
        checkOutput("async_reset_ready", dutReady(), 4'hf);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        doRead('hfffc);
        checkOutput("after_reset_hold0", bus.rd_io_data, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 6);
            if (pick < 4)       ra = BASE + AW'(pick);
            else if (pick == 4) ra = STAT;
            else if (pick == 5) ra = 'h1234;
            else                ra = AW'($urandom);
            rv = 4'($urandom) & 4'($urandom);
            applyStimulus(($urandom_range(0, 3) != 0), ra, rv,
                          DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
            runCycle();
        end
        doIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/memory_input_ports.md
MEMORY_INPUT_PORTS -- requirements
Module: memory_input_ports

Interface
REQ-001 Parameter PORT_BASE_ADDR, default 'hfffc, read address of input port 0; ports 1..3 at PORT_BASE_ADDR+1..+3.
REQ-002 Parameter STATUS_ADDR, default 'hfffb, read address of the status register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 rd_mem_en  input  1  processor read request, this cycle.
REQ-006 rd_mem_addr  input  MEMORY_ADDRESS_BITS  processor read address.
REQ-007 rd_io_data  output  MEMORY_DATA_BITS  registered read data, valid one cycle after an accepted read.
REQ-008 rd_io_hit  output  1  combinational; rd_mem_en high and rd_mem_addr equals one of the five mapped addresses.
REQ-009 rd_io_valid  output  1  registered; high the cycle after rd_io_hit was high, so the upstream mux selects rd_io_data over RAM data.
REQ-010 in_portN (N=0..3)  input  MEMORY_DATA_BITS  external data for port N.
REQ-011 in_portN_valid (N=0..3)  input  1  external device offers in_portN this cycle.
REQ-012 in_portN_ready (N=0..3)  output  1  combinational, equals NOT full[N].
REQ-013 MEMORY_DATA_BITS and MEMORY_ADDRESS_BITS are taken from constants_pkg; MEMORY_DATA_BITS SHALL be at least 8.

Function
REQ-014 Each port SHALL hold a one-entry buffer: hold[N] (MEMORY_DATA_BITS), full[N] (1 bit), overrun[N] (1 bit, sticky).
REQ-015 Capture: when in_portN_valid and in_portN_ready are both high at a rising edge, hold[N] <= in_portN and full[N] <= 1.
REQ-016 Overrun: when in_portN_valid is high while full[N] is 1, data SHALL be dropped, hold[N] unchanged, overrun[N] <= 1.
REQ-017 Port read: rd_io_hit with rd_mem_addr == PORT_BASE_ADDR+N SHALL register hold[N] into rd_io_data at the next edge and clear full[N] at that same edge.
REQ-018 Read of an empty port (full[N]==0) SHALL return the current hold[N] (last captured value, zero after reset) with no state change.
REQ-019 Read of an empty port coincident with a capture on that port: rd_io_data SHALL return the pre-capture hold[N]; capture proceeds, full[N] ends at 1.
REQ-020 Status read: rd_io_hit with rd_mem_addr == STATUS_ADDR SHALL return {zero-extension, overrun[3:0], full[3:0]} (full in bits 3:0, overrun in bits 7:4, upper bits 0).
REQ-021 Status read SHALL clear all overrun bits at the next edge; an overrun event in the same cycle SHALL win and leave that bit set.
REQ-022 Status read SHALL NOT modify full bits or hold registers.
REQ-023 Read latency SHALL be exactly one cycle; one read accepted per cycle, back-to-back reads supported.
REQ-024 When no hit occurs, rd_io_valid <= 0 and rd_io_data SHALL hold its previous value.
REQ-025 Ports are independent; captures on all four ports and one processor read SHALL all be able to occur in the same cycle.
REQ-026 Addresses outside the five mapped addresses SHALL produce rd_io_hit=0 and no state change.

Reset
REQ-027 While reset_n is low: hold[*]=0, full[*]=0, overrun[*]=0, rd_io_data=0, rd_io_valid=0, independent of clk.
REQ-028 in_portN_ready SHALL be 1 for all ports during and immediately after reset; rd_io_hit remains combinational.
REQ-029 Reset asserted mid-operation SHALL discard buffered data and pending read results; first edge after release behaves as from idle.

Verification
REQ-030 Reset release, read 'hfffc -> rd_io_valid=1 next cycle, rd_io_data=0; read 'hfffb -> data 0.
REQ-031 in_port2='h5a with valid for one cycle -> in_port2_ready drops to 0; status read returns 'h04; read 'hfffe returns 'h5a one cycle later; in_port2_ready returns to 1.
REQ-032 Capture 'h11 on port1, then offer 'h22 while full -> read 'hfffd returns 'h11; status shows 'h22 (full1 and overrun1 set) before port read; second status read after port read returns 'h00.
REQ-033 Same cycle: capture on all four ports plus read 'hfffc while port0 empty -> returned data is previous hold[0]; following status read returns 'h0f.
REQ-034 Back-to-back reads 'hfffc, 'hfffd, 'hfffe, 'hffff of 'hA0..'hA3 -> rd_io_data 'hA0..'hA3 on four consecutive cycles, rd_io_valid high throughout; read of 'h1234 -> rd_io_hit=0.
REQ-035 reset_n pulsed low asynchronously between edges while ports full -> all outputs zero immediately, ready=1 for all ports.
